// File: rtl/caster_mem_pkg.sv
// Shared encodings for the caster framebuffer memory scheduler:
// command opcodes, FSM states and the word size.
package caster_mem_pkg;

    localparam logic [2:0] CMD_RD = 3'b001;
    localparam logic [2:0] CMD_WR = 3'b000;

    localparam int WORD_BYTES = 8;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        WR_DATA = 2'd2,
        CMD     = 2'd3
    } state_t;

endpackage

// File: rtl/caster_mem_sched_if.sv
// MIG-style command port between the caster scheduler and the memory controller.
interface caster_mem_sched_if #(
    parameter int ADDR_W = 30
);
    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [5:0]        cmd_bl;
    logic              cmd_full;

    modport master (output cmd_en, cmd_instr, cmd_addr, cmd_bl, input cmd_full);
    modport slave  (input cmd_en, cmd_instr, cmd_addr, cmd_bl, output cmd_full);
endinterface

// File: rtl/caster_mem_arb.sv
// Read/write grant logic: urgent writes win outright, otherwise the type
// granted last loses a tie.
module caster_mem_arb (
    input  logic clk,
    input  logic rst,
    input  logic decide,
    input  logic rd_elig,
    input  logic wr_elig,
    input  logic wr_urgent,
    output logic grant_rd,
    output logic grant_wr
);
    logic last_rd;

    assign grant_wr = decide && wr_elig && (wr_urgent || !rd_elig || last_rd);
    assign grant_rd = decide && rd_elig && !grant_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          last_rd <= 1'b0;
        else if (grant_rd) last_rd <= 1'b1;
        else if (grant_wr) last_rd <= 1'b0;
    end
endmodule

// File: rtl/caster_mem_sched.sv
// Framebuffer burst scheduler: prefetches reads into the bi FIFO and writes
// the bo FIFO back in place, sharing one command port.
module caster_mem_sched
    import caster_mem_pkg::*;
#(
    parameter int ADDR_W      = 30,
    parameter int BASE_ADDR   = 0,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = 60000,
    parameter int FIFO_AW     = 9,
    parameter int WR_URGENT   = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               enable,
    input  logic [FIFO_AW-1:0] rd_fifo_space,
    input  logic               rd_data_valid,
    input  logic [FIFO_AW-1:0] wr_fifo_level,
    output logic               wr_xfer,
    input  logic               wr_xfer_done,
    caster_mem_sched_if.master cmd,
    output logic               frame_busy,
    output logic               err_late
);
    localparam int IW = $clog2(FRAME_WORDS + 1);
    localparam logic [IW-1:0]    FRAME_END = IW'(FRAME_WORDS);
    localparam logic [IW-1:0]    BURST_IDX = IW'(BURST_LEN);
    localparam logic [FIFO_AW:0] BURST_LVL = (FIFO_AW+1)'(BURST_LEN);
    localparam logic [FIFO_AW:0] URGENT_LVL = (FIFO_AW+1)'(WR_URGENT);

    state_t            state, state_nxt;
    logic [IW-1:0]     rd_idx, wr_idx, sel_idx;
    logic [FIFO_AW:0]  rd_inflight, rd_avail;
    logic [2:0]        instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q, late_q, xfer_q, restart_pend;
    logic              rd_elig, wr_elig, wr_urgent, frame_done, decide;
    logic              grant_rd, grant_wr, accept, restart, idle_start, inc, dec;

    // Unsigned at FIFO_AW+1 bits: space is assumed to cover outstanding reads.
    assign rd_avail   = {1'b0, rd_fifo_space} - rd_inflight;
    assign rd_elig    = (rd_idx < FRAME_END) && (rd_avail >= BURST_LVL);
    assign wr_elig    = (wr_idx < rd_idx) && ({1'b0, wr_fifo_level} >= BURST_LVL);
    assign wr_urgent  = {1'b0, wr_fifo_level} >= URGENT_LVL;
    assign frame_done = (rd_idx == FRAME_END) && (wr_idx == FRAME_END);
    assign decide     = (state == ARB) && enable && !frame_start && !frame_done;
    assign accept     = (state == CMD) && !cmd.cmd_full;
    assign idle_start = (state == IDLE) && frame_start && enable;
    // A restart seen during WR_DATA/CMD lands as the command retires.
    assign restart    = ((state == ARB) && frame_start) ||
                        (accept && (restart_pend || frame_start));
    assign inc        = accept && (instr_q == CMD_RD);
    assign dec        = rd_data_valid && ((rd_inflight != '0) || inc);
    assign sel_idx    = grant_rd ? rd_idx : wr_idx;

    caster_mem_arb u_arb (
        .clk, .rst, .decide, .rd_elig, .wr_elig, .wr_urgent, .grant_rd, .grant_wr
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (idle_start) state_nxt = ARB;
            ARB: begin
                if (grant_wr)                         state_nxt = WR_DATA;
                else if (grant_rd)                    state_nxt = CMD;
                else if (frame_done && !frame_start)  state_nxt = IDLE;
            end
            WR_DATA: if (wr_xfer_done) state_nxt = CMD;
            CMD:     if (accept)       state_nxt = ARB;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_idx       <= '0;
            wr_idx       <= '0;
            rd_inflight  <= '0;
            instr_q      <= CMD_WR;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            late_q       <= 1'b0;
            xfer_q       <= 1'b0;
            restart_pend <= 1'b0;
        end else begin
            xfer_q <= grant_wr;
            if (grant_rd || grant_wr) begin
                instr_q <= grant_rd ? CMD_RD : CMD_WR;
                addr_q  <= ADDR_W'(BASE_ADDR) + (ADDR_W'(sel_idx) << WORD_SHIFT);
            end
            if (frame_start && busy_q) late_q <= 1'b1;
            if (idle_start) busy_q <= 1'b1;
            else if ((state == ARB) && frame_done && !frame_start) busy_q <= 1'b0;

            if (accept)
                restart_pend <= 1'b0;
            else if (frame_start && ((state == WR_DATA) || (state == CMD)))
                restart_pend <= 1'b1;

            if (restart || idle_start) begin
                rd_idx <= '0;
                wr_idx <= '0;
            end else if (accept) begin
                if (instr_q == CMD_RD) rd_idx <= rd_idx + BURST_IDX;
                else                   wr_idx <= wr_idx + BURST_IDX;
            end

            rd_inflight <= rd_inflight + (inc ? BURST_LVL : '0) - (FIFO_AW+1)'(dec);
        end
    end

    assign cmd.cmd_en    = (state == CMD);
    assign cmd.cmd_instr = instr_q;
    assign cmd.cmd_addr  = addr_q;
    assign cmd.cmd_bl    = 6'(BURST_LEN - 1);
    assign wr_xfer       = xfer_q;
    assign frame_busy    = busy_q;
    assign err_late      = late_q;
endmodule
